// File: rtl/seven_seg_scanner_n.sv
// N-digit multiplexed seven-segment scanner: digit index, dwell counter, ghost gap, blanking, hex decode.
// Optional SEG_SCANNER_PWM_EN adds a 4-bit brightness input gating the lit window with a free-running PWM counter.
module seven_seg_scanner_n #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 4,
    parameter int GHOST_GAP = 1,
    localparam int IW       = $clog2(DIGITS)
) (
    input  logic                  div_clock,
    input  logic                  reset,
    input  logic                  enable,
`ifdef SEG_SCANNER_PWM_EN
    input  logic [3:0]            bright,
`endif
    input  logic [4*DIGITS-1:0]   hex_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    output logic [DIGITS-1:0]     anode,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [IW-1:0]         digit_sel,
    output logic                  frame_tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    logic          wrap_q;
    logic          dwell_end;
    logic          frame_end;
    logic          past_gap;
    logic          gate;
    logic          lit;
    logic [3:0]    nibble;

    function automatic logic [6:0] seg_of(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // A zero gap is resolved at elaboration so no always-true compare is built.
    generate
        if (GHOST_GAP == 0) begin : g_no_gap
            assign past_gap = 1'b1;
        end else begin : g_gap
            assign past_gap = (cnt >= CW'(GHOST_GAP));
        end
    endgenerate

`ifdef SEG_SCANNER_PWM_EN
    logic [3:0] pwm_cnt;

    always_ff @(posedge div_clock) begin
        if (!reset) pwm_cnt <= 4'd0;
        else        pwm_cnt <= pwm_cnt + 4'd1;
    end

    assign gate = (pwm_cnt < bright);
`else
    assign gate = 1'b1;
`endif

    assign dwell_end = (cnt == CNT_LAST);
    assign frame_end = dwell_end && (idx == IDX_LAST);
    assign nibble    = hex_in[{idx, 2'b00} +: 4];
    assign lit       = enable && past_gap && !blank_in[idx] && gate;

    // Outputs are a registered image of the (idx, cnt) slot that was current at this edge.
    always_ff @(posedge div_clock) begin
        if (!reset) begin
            idx        <= '0;
            cnt        <= '0;
            wrap_q     <= 1'b0;
            anode      <= '1;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            digit_sel  <= '0;
            frame_tick <= 1'b0;
        end else begin
            if (enable) begin
                if (dwell_end) begin
                    cnt <= '0;
                    idx <= frame_end ? '0 : idx + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            wrap_q     <= enable && frame_end;
            frame_tick <= wrap_q;
            digit_sel  <= idx;
            anode      <= lit ? ~(DIGITS'(1) << idx) : '1;
            seg        <= lit ? seg_of(nibble) : 7'h7F;
            dp         <= lit ? ~dp_in[idx] : 1'b1;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner_n.sv
// Bench for seven_seg_scanner_n at default parameters: per-cycle expectations from a slot-time model
// are queued by the driver and popped by a negedge monitor.
module tb_seven_seg_scanner_n;

    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 4;
    localparam int GHOST_GAP = 1;
    localparam int TOT       = DIGITS * SCAN_DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] hex_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_sel;
    logic        frame_tick;
`ifdef SEG_SCANNER_PWM_EN
    logic [3:0]  bright;
`endif

    always #5 clk = ~clk;

    seven_seg_scanner_n #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GHOST_GAP(GHOST_GAP)
    ) dut (
        .div_clock (clk),
        .reset     (reset),
        .enable    (enable),
`ifdef SEG_SCANNER_PWM_EN
        .bright    (bright),
`endif
        .hex_in    (hex_in),
        .dp_in     (dp_in),
        .blank_in  (blank_in),
        .anode     (anode),
        .seg       (seg),
        .dp        (dp),
        .digit_sel (digit_sel),
        .frame_tick(frame_tick)
    );

    typedef struct packed {
        int         cyc;
        logic [3:0] anode;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] sel;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;

    // Model: position within the frame as an enabled-cycle count.
    int   m_t    = 0;
    int   m_pwm  = 0;
    bit   m_wrap = 1'b0;
    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (anode !== e.anode || seg !== e.seg || dp !== e.dp ||
                digit_sel !== e.sel || frame_tick !== e.tick) begin
                fails++;
                $display("FAIL outputs cyc=%0d got anode=%h seg=%h dp=%b sel=%0d tick=%b want anode=%h seg=%h dp=%b sel=%0d tick=%b",
                         cyc, anode, seg, dp, digit_sel, frame_tick,
                         e.anode, e.seg, e.dp, e.sel, e.tick);
            end
        end
    end

    task automatic drive(input logic r, input logic e, input logic [15:0] h,
                         input logic [3:0] d, input logic [3:0] b);
        exp_t x;
        int   di;
        int   c;
        logic on;
        reset    = r;
        enable   = e;
        hex_in   = h;
        dp_in    = d;
        blank_in = b;
        x.cyc = cyc + 1;
        if (!r) begin
            x.anode = 4'hF; x.seg = 7'h7F; x.dp = 1'b1; x.sel = 2'd0; x.tick = 1'b0;
            m_t = 0; m_wrap = 1'b0; m_pwm = 0;
        end else begin
            di = m_t / SCAN_DIV;
            c  = m_t % SCAN_DIV;
            on = e && (c >= GHOST_GAP) && !b[di];
`ifdef SEG_SCANNER_PWM_EN
            on = on && (m_pwm < int'(bright));
`endif
            x.anode = on ? ~(4'b0001 << di) : 4'hF;
            x.seg   = on ? seg_tbl[h[4*di +: 4]] : 7'h7F;
            x.dp    = on ? ~d[di] : 1'b1;
            x.sel   = 2'(di);
            x.tick  = m_wrap;
            m_wrap  = e && (m_t == TOT - 1);
            if (e) m_t = (m_t + 1) % TOT;
            m_pwm = (m_pwm + 1) % 16;
        end
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] h;
`ifdef SEG_SCANNER_PWM_EN
        bright = 4'd15;
`endif
        drive(1'b0, 1'b0, 16'h0000, 4'h0, 4'h0);
        drive(1'b0, 1'b1, 16'h1234, 4'h0, 4'h0);
        repeat (40) drive(1'b1, 1'b1, 16'h1234, 4'h0, 4'h0);
        repeat (32) drive(1'b1, 1'b1, 16'h1234, 4'b0001, 4'b0100);

        // Freeze at digit 2, count 1 for ten cycles, then resume.
        for (int i = 0; i < TOT && m_t != 2 * SCAN_DIV + 1; i++)
            drive(1'b1, 1'b1, 16'hABCD, 4'b1010, 4'h0);
        repeat (10) drive(1'b1, 1'b0, 16'hABCD, 4'b1010, 4'h0);
        repeat (8) drive(1'b1, 1'b1, 16'hABCD, 4'b1010, 4'h0);

        // Reset pulse in the middle of digit 3's dwell.
        for (int i = 0; i < TOT && m_t != 3 * SCAN_DIV + 1; i++)
            drive(1'b1, 1'b1, 16'h5E0F, 4'h0, 4'h0);
        drive(1'b0, 1'b1, 16'h5E0F, 4'h0, 4'h0);
        repeat (20) drive(1'b1, 1'b1, 16'h5E0F, 4'h0, 4'h0);

        for (int i = 0; i < 300; i++) begin
            h = 16'($urandom);
`ifdef SEG_SCANNER_PWM_EN
            if (i % 32 == 0) bright = 4'($urandom_range(0, 15));
`endif
            drive($urandom_range(0, 49) != 0, $urandom_range(0, 7) != 0, h,
                  4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15) & $urandom_range(0, 15)));
        end
        drive(1'b1, 1'b1, 16'h89AB, 4'h0, 4'h0);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
